data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter WORD_ADDR_W, default 10, the word-address width, giving 2^WORD_ADDR_W 32-bit words.
REQ-002 SHALL have parameter LED_ADDR, default 32'h2000, the byte address of the memory-mapped LED register.
REQ-003 SHALL have parameter LED_W, default 8, the LED output width (1..32).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port addr, input, 32, the byte address.
REQ-007 SHALL have port write_data, input, 32, the store data, right-aligned.
REQ-008 SHALL have port memwrite, input, 1, the store request.
REQ-009 SHALL have port memread, input, 1, the load request.
REQ-010 SHALL have port sign_mask, input, 4, the access type: [3]=sign-extend, [2]=word, [1]=halfword, else byte.
REQ-011 SHALL have port read_data, output, 32, the extracted and extended load result.
REQ-012 SHALL have port led, output, LED_W, equal to led_reg[LED_W-1:0].
REQ-013 SHALL have port clk_stall, output, 1, high while a store merge is in progress.
REQ-014 SHALL have port misalign, output, 1, a one-cycle pulse flagging a rejected misaligned access.

Function
REQ-015 SHALL implement states IDLE and MERGE, with MERGE entered only from IDLE.
REQ-016 SHALL sample requests only in IDLE; in MERGE, all inputs are ignored.
REQ-017 SHALL decode size with sign_mask[2] before sign_mask[1]: [2]=1 word, else [1]=1 halfword, else byte.
REQ-018 SHALL index memory with word index addr[WORD_ADDR_W+1:2]; higher address bits alias.
REQ-019 SHALL flag as misaligned a halfword with addr[0]=1 or a word with addr[1:0]!=0.
REQ-020 SHALL, on a misaligned access sampled in IDLE, pulse misalign for one cycle, write nothing, set read_data to 0, and stay in IDLE.
REQ-021 SHALL, on an aligned load (memread=1) in IDLE at edge T, register the memory word, offset and sign_mask at T.
REQ-022 SHALL present the load result on read_data from after edge T and hold it until the next accepted load; this is one-cycle latency with no stall.
REQ-023 SHALL extract loads as: byte from lane addr[1:0]; halfword from lane pair addr[1]; word whole; upper bits are the sign bit when sign_mask[3]=1, else 0.
REQ-024 SHALL, on an aligned store at addr != LED_ADDR in IDLE at edge T, capture addr, write_data, sign_mask and the memory word, then go to MERGE and assert clk_stall.
REQ-025 SHALL, in MERGE at edge T+1, write the merged word, deassert clk_stall and return to IDLE.
REQ-026 SHALL, for a byte store in MERGE, replace only lane addr[1:0] with write_data[7:0].
REQ-027 SHALL, for a halfword store in MERGE, replace only lane pair addr[1] with write_data[15:0].
REQ-028 SHALL, for a word store in MERGE, replace the whole word with write_data.
REQ-029 SHALL, on a store to addr == LED_ADDR in IDLE, load led_reg with write_data in one cycle, with no stall and no memory write.
REQ-030 SHALL give load priority when memread and memwrite are both high in IDLE: the load completes and the store is dropped.
REQ-031 SHALL accept a new request in the first IDLE cycle after MERGE, allowing back-to-back stores with one stall cycle each.
REQ-032 SHALL make a load of a just-merged word return the merged value.
REQ-033 SHALL leave read_data unchanged during a store and its MERGE.

Reset
REQ-034 SHALL, while rst is high, asynchronously force state=IDLE, clk_stall=0, misalign=0, read_data=0 and led_reg=0.
REQ-035 SHALL abort a MERGE that rst interrupts without writing memory; memory contents are not reset.
REQ-036 SHALL resume request sampling on the first rising clk edge after rst deasserts.

Verification
REQ-037 SHALL cover: word store 32'hDEADBEEF to 0x10, then signed byte load of 0x13 -> clk_stall high for exactly 1 cycle, read_data=32'hFFFFFFDE.
REQ-038 SHALL cover: halfword store 16'h1234 to 0x12 over word 0xDEADBEEF, then word load of 0x10 -> read_data=32'h1234BEEF.
REQ-039 SHALL cover: unsigned halfword load of 0x11 -> misalign pulses 1 cycle, read_data=0, memory unchanged.
REQ-040 SHALL cover: store 32'hA5 to 0x2000 -> led=8'hA5 next cycle, clk_stall stays 0, word at index 0x800 mod depth unchanged.
REQ-041 SHALL cover: memread and memwrite both high at 0x20 -> load value returned and memory at 0x20 unchanged.
REQ-042 SHALL cover: rst asserted mid-MERGE of a store to 0x30 -> clk_stall=0 and led=0 immediately, and word 0x30 keeps its old value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/halfword/word loads with one-cycle latency,
// read-modify-write stores with a one-cycle stall, and a memory-mapped LED register.
module data_mem_ctrl #(
   parameter int unsigned WORD_ADDR_W = 10,
   parameter logic [31:0] LED_ADDR    = 32'h2000,
   parameter int unsigned LED_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic [31:0]      write_data,
   input  logic             memwrite,
   input  logic             memread,
   input  logic [3:0]       sign_mask,
   output logic [31:0]      read_data,
   output logic [LED_W-1:0] led,
   output logic             clk_stall,
   output logic             misalign
);

   localparam int unsigned Depth = 2 ** WORD_ADDR_W;

   typedef enum logic [0:0] {StIdle, StMerge} state_e;

   state_e state_q, state_d;

   logic [31:0] mem [Depth];

   logic [WORD_ADDR_W-1:0] idx;
   logic [31:0]            mem_word;
   logic                   is_word, is_half, misaligned, idle;
   logic                   mis_hit, load_go, led_go, store_go;

   logic [31:0]            ld_word_q;
   logic [1:0]             ld_off_q;
   logic [3:0]             ld_mask_q;

   logic [WORD_ADDR_W-1:0] st_idx_q;
   logic [1:0]             st_off_q;
   logic [31:0]            st_data_q;
   logic [3:0]             st_mask_q;
   logic [31:0]            st_word_q;
   logic [31:0]            merged;

   logic [LED_W-1:0]       led_q;
   logic                   misalign_q;

   assign idx      = addr[WORD_ADDR_W+1:2];
   assign mem_word = mem[idx];
   assign is_word  = sign_mask[2];
   assign is_half  = !sign_mask[2] && sign_mask[1];
   assign misaligned = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
   assign idle     = (state_q == StIdle);

   // Misalignment beats everything; a load beats a store when both are requested.
   assign mis_hit  = idle && (memread || memwrite) && misaligned;
   assign load_go  = idle && memread && !misaligned;
   assign led_go   = idle && memwrite && !memread && !misaligned && (addr == LED_ADDR);
   assign store_go = idle && memwrite && !memread && !misaligned && (addr != LED_ADDR);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (store_go) state_d = StMerge;
         StMerge: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         misalign_q <= 1'b0;
         led_q      <= '0;
         ld_word_q  <= '0;
         ld_off_q   <= '0;
         ld_mask_q  <= '0;
      end else begin
         state_q    <= state_d;
         misalign_q <= mis_hit;
         if (led_go) led_q <= write_data[LED_W-1:0];
         if (load_go) begin
            ld_word_q <= mem_word;
            ld_off_q  <= addr[1:0];
            ld_mask_q <= sign_mask;
         end else if (mis_hit) begin
            // Zero word with an unsigned byte access extracts to zero.
            ld_word_q <= '0;
            ld_off_q  <= '0;
            ld_mask_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_idx_q  <= '0;
         st_off_q  <= '0;
         st_data_q <= '0;
         st_mask_q <= '0;
         st_word_q <= '0;
      end else if (store_go) begin
         st_idx_q  <= idx;
         st_off_q  <= addr[1:0];
         st_data_q <= write_data;
         st_mask_q <= sign_mask;
         st_word_q <= mem_word;
      end
   end

   always_comb begin
      merged = st_word_q;
      if (st_mask_q[2]) begin
         merged = st_data_q;
      end else if (st_mask_q[1]) begin
         if (st_off_q[1]) merged[31:16] = st_data_q[15:0];
         else             merged[15:0]  = st_data_q[15:0];
      end else begin
         unique case (st_off_q)
            2'd0: merged[7:0]   = st_data_q[7:0];
            2'd1: merged[15:8]  = st_data_q[7:0];
            2'd2: merged[23:16] = st_data_q[7:0];
            2'd3: merged[31:24] = st_data_q[7:0];
            default: merged = st_word_q;
         endcase
      end
   end

   // Memory is not reset; a reset during MERGE drops the pending write.
   always_ff @(posedge clk) begin
      if (state_q == StMerge && !rst) mem[st_idx_q] <= merged;
   end

   always_comb begin
      read_data = '0;
      if (ld_mask_q[2]) begin
         read_data = ld_word_q;
      end else if (ld_mask_q[1]) begin
         read_data[15:0]  = ld_off_q[1] ? ld_word_q[31:16] : ld_word_q[15:0];
         read_data[31:16] = {16{ld_mask_q[3] & read_data[15]}};
      end else begin
         unique case (ld_off_q)
            2'd0: read_data[7:0] = ld_word_q[7:0];
            2'd1: read_data[7:0] = ld_word_q[15:8];
            2'd2: read_data[7:0] = ld_word_q[23:16];
            2'd3: read_data[7:0] = ld_word_q[31:24];
            default: read_data[7:0] = '0;
         endcase
         read_data[31:8] = {24{ld_mask_q[3] & read_data[7]}};
      end
   end

   assign clk_stall = (state_q == StMerge);
   assign misalign  = misalign_q;
   assign led       = led_q;

endmodule
